mmio_timer_core: RTL



---
 rtl/mmio_timer_core_pkg.sv | 19 +
 rtl/mmio_timer_core_if.sv | 24 ++
 rtl/mmio_timer_core_counter.sv | 23 ++
 rtl/mmio_timer_core.sv | 85 ++++++++
 4 files changed

// File: rtl/mmio_timer_core_pkg.sv
// Register map and bit positions for the MMIO slot timer.
// Shared by the slot interface, the core and the bench.
package mmio_timer_pkg;

  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_COUNT_LO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_COUNT_HI = 5'd1;
  localparam logic [ADDR_W-1:0] REG_CTRL     = 5'd2;
  localparam logic [ADDR_W-1:0] REG_CMP      = 5'd3;
  localparam logic [ADDR_W-1:0] REG_STATUS   = 5'd4;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_MATCH  = 0;

endpackage

// File: rtl/mmio_timer_core_if.sv
// Per-slot MMIO signals between the controller (master) and one slot responder (slave).
// rd_data is combinational from addr; strobes are single-cycle, qualified by cs.
interface mmio_timer_core_if;
  import mmio_timer_pkg::*;

  logic              cs;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wr_data;
  logic [31:0]       rd_data;
  logic              irq;

  modport master (
    output cs, read, write, addr, wr_data,
    input  rd_data, irq
  );

  modport slave (
    input  cs, read, write, addr, wr_data,
    output rd_data, irq
  );

endinterface

// File: rtl/mmio_timer_core_counter.sv
// Free-running counter: clear beats enable, wraps silently at 2^W-1.
// One-cycle update latency; no backpressure.
module timer_counter #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/mmio_timer_core.sv
// MMIO slot timer: COUNT_W-bit counter, torn-read-safe high snapshot, compare flag, irq.
// Zero-latency combinational read data; register writes land at the next edge, never stalls.
module mmio_timer_core
  import mmio_timer_pkg::*;
#(
  parameter int COUNT_W = 48
) (
  input  logic               clk,
  input  logic               reset,
  mmio_timer_core_if.slave   bus
);

  localparam int HI_W = COUNT_W - 32;

  logic               wr_en;
  logic               rd_en;
  logic               clr_pulse;
  logic               match_set;
  logic               w1c;
  logic               go;
  logic               irq_en;
  logic               match_flag;
  logic [31:0]        cmp;
  logic [HI_W-1:0]    hi_shadow;
  logic [COUNT_W-1:0] count;

  assign wr_en     = bus.cs & bus.write;
  assign rd_en     = bus.cs & bus.read;
  assign clr_pulse = wr_en && (bus.addr == REG_CTRL) && bus.wr_data[CTRL_CLR];
  assign w1c       = wr_en && (bus.addr == REG_STATUS) && bus.wr_data[STAT_MATCH];
  // Compare sees the pre-increment value; a clearing cycle never matches.
  assign match_set = go && !clr_pulse && (count[31:0] == cmp);

  timer_counter #(.W(COUNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_pulse),
    .en    (go),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go         <= 1'b0;
      irq_en     <= 1'b0;
      cmp        <= '0;
      hi_shadow  <= '0;
      match_flag <= 1'b0;
    end else begin
      if (wr_en && (bus.addr == REG_CTRL)) begin
        go     <= bus.wr_data[CTRL_GO];
        irq_en <= bus.wr_data[CTRL_IRQ_EN];
      end
      if (wr_en && (bus.addr == REG_CMP)) begin
        cmp <= bus.wr_data;
      end
      if (rd_en && (bus.addr == REG_COUNT_LO)) begin
        hi_shadow <= count[COUNT_W-1:32];
      end
      if (match_set) begin
        match_flag <= 1'b1;
      end else if (w1c) begin
        match_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    case (bus.addr)
      REG_COUNT_LO: bus.rd_data = count[31:0];
      REG_COUNT_HI: bus.rd_data = 32'(hi_shadow);
      REG_CTRL: begin
        bus.rd_data[CTRL_GO]     = go;
        bus.rd_data[CTRL_IRQ_EN] = irq_en;
      end
      REG_CMP:      bus.rd_data = cmp;
      REG_STATUS:   bus.rd_data[STAT_MATCH] = match_flag;
      default:      bus.rd_data = '0;
    endcase
  end

  assign bus.irq = match_flag & irq_en;

endmodule
